// File: rtl/mr_lsu.sv
// Load/store stage: takes one op at a time from the ALU stage, runs memory ops on a
// single-outstanding word bus, and hands aligned/extended results to writeback.
module mr_lsu #(
    parameter int XLEN        = 32,
    parameter int REGSEL_BITS = 5,
    parameter int MEM_OP_BITS = 2,
    parameter int MEM_SZ_BITS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ls_valid,
    output logic                   ls_ready,
    input  logic [XLEN-1:0]        ls_dest,
    input  logic [REGSEL_BITS-1:0] ls_dest_reg,
    input  logic [MEM_OP_BITS-1:0] ls_memop,
    input  logic [MEM_SZ_BITS-1:0] ls_size,
    input  logic                   ls_signed,
    input  logic [XLEN-1:0]        ls_payload,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [XLEN-1:0]        mem_addr,
    output logic                   mem_we,
    output logic [XLEN/8-1:0]      mem_wstrb,
    output logic [XLEN-1:0]        mem_wdata,
    input  logic                   mem_rsp_valid,
    input  logic [XLEN-1:0]        mem_rdata,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [REGSEL_BITS-1:0] wb_reg,
    output logic [XLEN-1:0]        wb_data,
    output logic                   wb_err
);
    localparam int NB = XLEN / 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

    state_t                 r_state, w_next, w_accept_next;
    logic                   w_accept, w_is_load, w_is_store, w_misaligned;
    logic [1:0]             w_off;
    logic [NB-1:0]          w_wstrb;
    logic [XLEN-1:0]        w_wdata, w_shift, w_ext;

    logic                   r_is_store;
    logic [MEM_SZ_BITS-1:0] r_size;
    logic                   r_signed;
    logic [1:0]             r_off;
    logic [XLEN-1:0]        r_mem_addr, r_mem_wdata, r_wb_data;
    logic [NB-1:0]          r_mem_wstrb;
    logic                   r_mem_we;
    logic [REGSEL_BITS-1:0] r_wb_reg;
    logic                   r_wb_err;

    // NOTE: ls_ready is gated by rst_n so it reads 0 while reset is held, not just after.
    assign ls_ready   = rst_n && ((r_state == S_IDLE) || ((r_state == S_WB) && wb_ready));
    assign w_accept   = ls_valid && ls_ready;
    assign w_is_load  = (ls_memop == MEM_OP_BITS'(1));
    assign w_is_store = (ls_memop == MEM_OP_BITS'(2));
    assign w_off      = ls_dest[1:0];

    always_comb begin
        w_misaligned = 1'b1;
        w_wstrb      = '1;
        w_wdata      = ls_payload;
        case (ls_size)
            MEM_SZ_BITS'(0): begin
                w_misaligned = 1'b0;
                w_wstrb      = NB'(1) << w_off;
                w_wdata      = {NB{ls_payload[7:0]}};
            end
            MEM_SZ_BITS'(1): begin
                w_misaligned = ls_dest[0];
                w_wstrb      = NB'(3) << w_off;
                w_wdata      = {(XLEN/16){ls_payload[15:0]}};
            end
            MEM_SZ_BITS'(2): w_misaligned = |ls_dest[1:0];
            default:         w_misaligned = 1'b1;
        endcase
    end

    assign w_accept_next = ((w_is_load || w_is_store) && !w_misaligned) ? S_REQ : S_WB;

    // Load data: shift the addressed lane down to bit 0, then extend to XLEN.
    assign w_shift = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_ext = w_shift;
        case (r_size)
            MEM_SZ_BITS'(0): w_ext = {{(XLEN-8){r_signed & w_shift[7]}}, w_shift[7:0]};
            MEM_SZ_BITS'(1): w_ext = {{(XLEN-16){r_signed & w_shift[15]}}, w_shift[15:0]};
            default:         w_ext = w_shift;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_next = w_accept_next;
            S_REQ:  if (mem_req_ready) w_next = r_is_store ? S_IDLE : S_WAIT;
            S_WAIT: if (mem_rsp_valid) w_next = S_WB;
            S_WB:   if (wb_ready) w_next = w_accept ? w_accept_next : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_store  <= 1'b0;
            r_size      <= '0;
            r_signed    <= 1'b0;
            r_off       <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= '0;
            r_mem_wdata <= '0;
            r_wb_reg    <= '0;
            r_wb_data   <= '0;
            r_wb_err    <= 1'b0;
        end else if (w_accept) begin
            r_is_store  <= w_is_store;
            r_size      <= ls_size;
            r_signed    <= ls_signed;
            r_off       <= w_off;
            r_mem_addr  <= {ls_dest[XLEN-1:2], 2'b00};
            r_mem_we    <= w_is_store;
            r_mem_wstrb <= w_is_store ? w_wstrb : '0;
            r_mem_wdata <= w_is_store ? w_wdata : '0;
            r_wb_reg    <= ls_dest_reg;
            r_wb_data   <= ls_dest;
            r_wb_err    <= (w_is_load || w_is_store) && w_misaligned;
        end else if ((r_state == S_WAIT) && mem_rsp_valid) begin
            r_wb_data   <= w_ext;
            r_wb_err    <= 1'b0;
        end
    end

    assign mem_req_valid = (r_state == S_REQ);
    assign mem_addr      = r_mem_addr;
    assign mem_we        = r_mem_we;
    assign mem_wstrb     = r_mem_wstrb;
    assign mem_wdata     = r_mem_wdata;
    assign wb_valid      = (r_state == S_WB);
    assign wb_reg        = r_wb_reg;
    assign wb_data       = r_wb_data;
    assign wb_err        = r_wb_err;
endmodule

// File: tb/tb_mr_lsu.sv
// Directed bench for mr_lsu: a vector table of single ops with exact-latency checks,
// plus hand sequences for bus stall, writeback backpressure and mid-op reset.
module tb_mr_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ls_valid, ls_ready, ls_signed;
    logic [31:0] ls_dest, ls_payload;
    logic [4:0]  ls_dest_reg;
    logic [1:0]  ls_memop, ls_size;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        wb_valid, wb_ready, wb_err;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_errors = 0;

    mr_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_dest(ls_dest),
        .ls_dest_reg(ls_dest_reg), .ls_memop(ls_memop), .ls_size(ls_size),
        .ls_signed(ls_signed), .ls_payload(ls_payload),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg),
        .wb_data(wb_data), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    typedef enum {K_WB, K_LOAD, K_STORE} kind_t;

    typedef struct {
        string       name;
        kind_t       kind;
        logic [1:0]  memop;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] dest;
        logic [4:0]  rg;
        logic [31:0] payload;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input kind_t k, input logic [1:0] op,
                                input logic [1:0] sz, input logic sg, input logic [31:0] dest,
                                input logic [4:0] rg, input logic [31:0] pay,
                                input logic [31:0] rdata, input logic [31:0] addr,
                                input logic [3:0] strb, input logic [31:0] wdata,
                                input logic [31:0] data, input logic err);
        vec_t v;
        v.name = name; v.kind = k; v.memop = op; v.size = sz; v.sgn = sg;
        v.dest = dest; v.rg = rg; v.payload = pay; v.rdata = rdata;
        v.exp_addr = addr; v.exp_wstrb = strb; v.exp_wdata = wdata;
        v.exp_data = data; v.exp_err = err;
        return v;
    endfunction

    task automatic drive_op(input logic [1:0] op, input logic [1:0] sz, input logic sg,
                            input logic [31:0] dest, input logic [4:0] rg, input logic [31:0] pay);
        ls_valid = 1'b1; ls_memop = op; ls_size = sz; ls_signed = sg;
        ls_dest = dest; ls_dest_reg = rg; ls_payload = pay;
    endtask

    task automatic junk_op();
        ls_valid = 1'b0; ls_memop = 2'd1; ls_size = 2'd2; ls_signed = 1'b1;
        ls_dest = 32'hFFFF_FFF0; ls_dest_reg = 5'd31; ls_payload = 32'hFFFF_FFFF;
    endtask

    // One op through the stage with ready sinks; checks the exact cycle of each event.
    task automatic run_vec(input vec_t v);
        mem_req_ready = 1'b1; wb_ready = 1'b1;
        drive_op(v.memop, v.size, v.sgn, v.dest, v.rg, v.payload);
        @(negedge clk);
        check({v.name, ":ls_ready"}, ls_ready, 1);
        @(posedge clk); #1;
        junk_op();
        @(negedge clk);
        if (v.kind == K_WB) begin
            check({v.name, ":req_valid"}, mem_req_valid, 0);
            check({v.name, ":wb_valid"}, wb_valid, 1);
            check({v.name, ":wb_reg"}, wb_reg, v.rg);
            check({v.name, ":wb_data"}, wb_data, v.exp_data);
            check({v.name, ":wb_err"}, wb_err, v.exp_err);
        end else begin
            check({v.name, ":req_valid"}, mem_req_valid, 1);
            check({v.name, ":wb_valid_req"}, wb_valid, 0);
            check({v.name, ":mem_addr"}, mem_addr, v.exp_addr);
            check({v.name, ":mem_we"}, mem_we, (v.kind == K_STORE));
            check({v.name, ":mem_wstrb"}, mem_wstrb, v.exp_wstrb);
            check({v.name, ":mem_wdata"}, mem_wdata, v.exp_wdata);
            @(posedge clk); #1;
            if (v.kind == K_LOAD) begin
                mem_rsp_valid = 1'b1; mem_rdata = v.rdata;
                @(negedge clk);
                check({v.name, ":req_dropped"}, mem_req_valid, 0);
                check({v.name, ":wb_valid_wait"}, wb_valid, 0);
                @(posedge clk); #1;
                mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
                @(negedge clk);
                check({v.name, ":wb_valid"}, wb_valid, 1);
                check({v.name, ":wb_reg"}, wb_reg, v.rg);
                check({v.name, ":wb_data"}, wb_data, v.exp_data);
                check({v.name, ":wb_err"}, wb_err, 0);
            end else begin
                @(negedge clk);
                check({v.name, ":store_done_req"}, mem_req_valid, 0);
                check({v.name, ":store_no_wb"}, wb_valid, 0);
                check({v.name, ":store_idle"}, ls_ready, 1);
            end
        end
        if (v.kind != K_STORE) begin
            @(posedge clk); #1;
            @(negedge clk);
            check({v.name, ":drained"}, wb_valid, 0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk("none",     K_WB,    2'd0, 2'd0, 1'b0, 32'h1234, 5'd5,  32'h0,        32'h0,        32'h0,   4'h0, 32'h0,        32'h1234,     1'b0);
        vecs[1]  = mk("lb_s",     K_LOAD,  2'd1, 2'd0, 1'b1, 32'h103,  5'd7,  32'h0,        32'h80FFFFFF, 32'h100, 4'h0, 32'h0,        32'hFFFFFF80, 1'b0);
        vecs[2]  = mk("lbu",      K_LOAD,  2'd1, 2'd0, 1'b0, 32'h103,  5'd7,  32'h0,        32'h80FFFFFF, 32'h100, 4'h0, 32'h0,        32'h00000080, 1'b0);
        vecs[3]  = mk("lw_mis",   K_WB,    2'd1, 2'd2, 1'b0, 32'h101,  5'd3,  32'h0,        32'h0,        32'h0,   4'h0, 32'h0,        32'h101,      1'b1);
        vecs[4]  = mk("lh_s",     K_LOAD,  2'd1, 2'd1, 1'b1, 32'h102,  5'd4,  32'h0,        32'hBEEF1234, 32'h100, 4'h0, 32'h0,        32'hFFFFBEEF, 1'b0);
        vecs[5]  = mk("sb",       K_STORE, 2'd2, 2'd0, 1'b0, 32'h301,  5'd0,  32'h000000A5, 32'h0,        32'h300, 4'h2, 32'hA5A5A5A5, 32'h0,        1'b0);
        vecs[6]  = mk("sw",       K_STORE, 2'd2, 2'd2, 1'b0, 32'h400,  5'd0,  32'hDEADBEEF, 32'h0,        32'h400, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0);
        vecs[7]  = mk("lw",       K_LOAD,  2'd1, 2'd2, 1'b1, 32'h500,  5'd8,  32'h0,        32'h12345678, 32'h500, 4'h0, 32'h0,        32'h12345678, 1'b0);
        vecs[8]  = mk("sz3",      K_WB,    2'd2, 2'd3, 1'b0, 32'h600,  5'd10, 32'h55,       32'h0,        32'h0,   4'h0, 32'h0,        32'h600,      1'b1);
        vecs[9]  = mk("memop3",   K_WB,    2'd3, 2'd2, 1'b0, 32'h77,   5'd9,  32'h99,       32'h0,        32'h0,   4'h0, 32'h0,        32'h77,       1'b0);
        vecs[10] = mk("lhu",      K_LOAD,  2'd1, 2'd1, 1'b0, 32'h2,    5'd11, 32'h0,        32'h80010000, 32'h0,   4'h0, 32'h0,        32'h00008001, 1'b0);
        vecs[11] = mk("sh_mis",   K_WB,    2'd2, 2'd1, 1'b0, 32'h203,  5'd12, 32'h1,        32'h0,        32'h0,   4'h0, 32'h0,        32'h203,      1'b1);
        vecs[12] = mk("lb_pos",   K_LOAD,  2'd1, 2'd0, 1'b1, 32'h0,    5'd13, 32'h0,        32'h1234567F, 32'h0,   4'h0, 32'h0,        32'h0000007F, 1'b0);
        vecs[13] = mk("sh_lo",    K_STORE, 2'd2, 2'd1, 1'b0, 32'h200,  5'd0,  32'hABCD1234, 32'h0,        32'h200, 4'h3, 32'h12341234, 32'h0,        1'b0);
        vecs[14] = mk("lb_s_b1",  K_LOAD,  2'd1, 2'd0, 1'b1, 32'h201,  5'd14, 32'h0,        32'h0000C300, 32'h200, 4'h0, 32'h0,        32'hFFFFFFC3, 1'b0);

        rst_n = 1'b0; junk_op(); mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        mem_rdata = 32'h0; wb_ready = 1'b0;
        #12;
        check("rst:ls_ready", ls_ready, 0);
        check("rst:req_valid", mem_req_valid, 0);
        check("rst:wb_valid", wb_valid, 0);
        check("rst:wb_err", wb_err, 0);
        check("rst:wb_data", wb_data, 0);
        check("rst:mem_addr", mem_addr, 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // Store with the bus stalled for 3 cycles: request fields must hold.
        mem_req_ready = 1'b1; wb_ready = 1'b1;
        drive_op(2'd2, 2'd1, 1'b0, 32'h202, 5'd1, 32'hABCD1234);
        @(posedge clk); #1;
        junk_op(); mem_req_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) mem_req_ready = 1'b1;
            @(negedge clk);
            check("stall:req_valid", mem_req_valid, 1);
            check("stall:mem_addr", mem_addr, 32'h200);
            check("stall:mem_wstrb", mem_wstrb, 4'b1100);
            check("stall:mem_wdata", mem_wdata, 32'h12341234);
            check("stall:mem_we", mem_we, 1);
            check("stall:wb_valid", wb_valid, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("stall:idle_req", mem_req_valid, 0);
        check("stall:idle_wb", wb_valid, 0);
        check("stall:idle_ready", ls_ready, 1);
        @(posedge clk); #1;

        // Writeback backpressure with the next op pending, then same-cycle accept.
        wb_ready = 1'b0;
        drive_op(2'd0, 2'd0, 1'b0, 32'hAAAA, 5'd1, 32'h0);
        @(posedge clk); #1;
        drive_op(2'd0, 2'd0, 1'b0, 32'hBBBB, 5'd2, 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("bp:wb_valid", wb_valid, 1);
            check("bp:ls_ready", ls_ready, 0);
            check("bp:wb_data_hold", wb_data, 32'hAAAA);
            check("bp:wb_reg_hold", wb_reg, 5'd1);
            @(posedge clk); #1;
        end
        wb_ready = 1'b1;
        @(negedge clk);
        check("bp:ls_ready_drain", ls_ready, 1);
        check("bp:wb_data_drain", wb_data, 32'hAAAA);
        @(posedge clk); #1;
        junk_op();
        @(negedge clk);
        check("bp:next_valid", wb_valid, 1);
        check("bp:next_data", wb_data, 32'hBBBB);
        check("bp:next_reg", wb_reg, 5'd2);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp:drained", wb_valid, 0);
        @(posedge clk); #1;

        // Reset while waiting for load data; the late response must be ignored.
        mem_req_ready = 1'b1;
        drive_op(2'd1, 2'd2, 1'b0, 32'h700, 5'd6, 32'h0);
        @(posedge clk); #1;
        junk_op();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mrst:req_valid", mem_req_valid, 0);
        check("mrst:wb_valid", wb_valid, 0);
        check("mrst:ls_ready", ls_ready, 0);
        check("mrst:mem_addr", mem_addr, 0);
        check("mrst:wb_data", wb_data, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("mrst:idle_ready", ls_ready, 1);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        check("mrst:stale_wb", wb_valid, 0);
        check("mrst:stale_req", mem_req_valid, 0);
        @(posedge clk); #1;
        run_vec(vecs[1]);
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
